// File: rtl/udp_dispatch_pkg.sv
// Shared definitions for the UDP RX port dispatcher: metadata layout, FSM states
// and small helpers used by the dispatcher and its port matcher.
package udp_dispatch_pkg;

    localparam int UDP_META_W      = 176;

    localparam int REMOTE_IP_OFF   = 0;
    localparam int REMOTE_IP_W     = 128;
    localparam int REMOTE_PORT_OFF = 128;
    localparam int REMOTE_PORT_W   = 16;
    localparam int LOCAL_PORT_OFF  = 144;
    localparam int LOCAL_PORT_W    = 16;
    localparam int LENGTH_OFF      = 160;
    localparam int LENGTH_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FWD,
        ST_DROP
    } dispatch_state_t;

    // Field order mirrors the bit layout: length occupies the top bits.
    typedef struct packed {
        logic [LENGTH_W-1:0]      length;
        logic [LOCAL_PORT_W-1:0]  local_port;
        logic [REMOTE_PORT_W-1:0] remote_port;
        logic [REMOTE_IP_W-1:0]   remote_ip;
    } udp_meta_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority matcher: finds the lowest enabled port-table entry
// equal to the requested destination port.
module udp_port_match
    import udp_dispatch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [LOCAL_PORT_W-1:0]  port,
    input  logic [16*NUM_PORTS-1:0]  port_table,
    input  logic [NUM_PORTS-1:0]     port_enable,
    output logic                     hit,
    output logic [IDX_W-1:0]         index
);

    always_comb begin
        hit   = 1'b0;
        index = '0;
        // Ascending scan guarded by hit keeps the lowest matching entry.
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!hit && port_enable[i] && (port_table[16*i +: 16] == port)) begin
                hit   = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_rx_port_dispatch.sv
// Routes each UDP RX packet (metadata + payload) to the role channel whose
// port-table entry matches the destination port; unmatched packets go to a
// default channel or are drained and counted.
module udp_rx_port_dispatch
    import udp_dispatch_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int NUM_PORTS  = 4,
    parameter int DEFAULT_EN = 0,
    parameter int DEFAULT_CH = 0
) (
    input  logic                    net_clk,
    input  logic                    net_aresetn,

    input  logic                    s_meta_valid,
    output logic                    s_meta_ready,
    input  logic [UDP_META_W-1:0]   s_meta_data,

    input  logic                    s_data_valid,
    output logic                    s_data_ready,
    input  logic [WIDTH-1:0]        s_data_data,
    input  logic [WIDTH/8-1:0]      s_data_keep,
    input  logic                    s_data_last,

    output logic [NUM_PORTS-1:0]    m_meta_valid,
    input  logic [NUM_PORTS-1:0]    m_meta_ready,
    output logic [UDP_META_W-1:0]   m_meta_data,

    output logic [NUM_PORTS-1:0]    m_data_valid,
    input  logic [NUM_PORTS-1:0]    m_data_ready,
    output logic [WIDTH-1:0]        m_data_data,
    output logic [WIDTH/8-1:0]      m_data_keep,
    output logic                    m_data_last,

    input  logic [16*NUM_PORTS-1:0] port_table,
    input  logic [NUM_PORTS-1:0]    port_enable,

    output logic [31:0]             fwd_count,
    output logic [31:0]             drop_count
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    dispatch_state_t      state;
    udp_meta_t            meta_r;
    logic                 meta_ready_r;
    logic [IDX_W-1:0]     sel;
    logic                 meta_done;
    logic                 data_done;

    logic                 match_hit;
    logic [IDX_W-1:0]     match_idx;
    logic [IDX_W-1:0]     lookup_sel;
    logic [NUM_PORTS-1:0] lookup_oh;
    logic [NUM_PORTS-1:0] sel_oh;

    logic                 meta_hs;
    logic                 last_hs;
    logic                 pkt_done;

    udp_port_match #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_match (
        .port        (meta_r.local_port),
        .port_table  (port_table),
        .port_enable (port_enable),
        .hit         (match_hit),
        .index       (match_idx)
    );

    always_comb begin
        lookup_sel = match_hit ? match_idx : IDX_W'(DEFAULT_CH);
        lookup_oh  = '0;
        sel_oh     = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            lookup_oh[i] = (lookup_sel == IDX_W'(i));
            sel_oh[i]    = (sel == IDX_W'(i));
        end
    end

    // Payload is a combinational pass-through; once the last beat is taken the
    // channel is closed so the next packet's data cannot slip in early.
    always_comb begin
        m_data_valid = '0;
        s_data_ready = 1'b0;
        case (state)
            ST_FWD: begin
                if (!data_done) begin
                    m_data_valid = sel_oh & {NUM_PORTS{s_data_valid}};
                    s_data_ready = |(sel_oh & m_data_ready);
                end
            end
            ST_DROP: s_data_ready = 1'b1;
            default: ;
        endcase
    end

    assign meta_hs  = |(m_meta_valid & m_meta_ready);
    assign last_hs  = s_data_valid & s_data_ready & s_data_last;
    assign pkt_done = (state == ST_FWD) & (meta_done | meta_hs) & (data_done | last_hs);

    assign s_meta_ready = meta_ready_r;
    assign m_meta_data  = meta_r;
    assign m_data_data  = s_data_data;
    assign m_data_keep  = s_data_keep;
    assign m_data_last  = s_data_last;

    always_ff @(posedge net_clk or negedge net_aresetn) begin
        if (!net_aresetn) begin
            state        <= ST_IDLE;
            meta_r       <= '0;
            meta_ready_r <= 1'b0;
            m_meta_valid <= '0;
            sel          <= '0;
            meta_done    <= 1'b0;
            data_done    <= 1'b0;
            fwd_count    <= '0;
            drop_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    meta_ready_r <= 1'b1;
                    if (s_meta_valid && meta_ready_r) begin
                        meta_r       <= s_meta_data;
                        meta_ready_r <= 1'b0;
                        state        <= ST_LOOKUP;
                    end
                end

                ST_LOOKUP: begin
                    meta_done <= 1'b0;
                    data_done <= 1'b0;
                    if (match_hit || (DEFAULT_EN != 0)) begin
                        sel          <= lookup_sel;
                        m_meta_valid <= lookup_oh;
                        state        <= ST_FWD;
                    end else begin
                        state <= ST_DROP;
                    end
                end

                ST_FWD: begin
                    if (meta_hs) begin
                        meta_done    <= 1'b1;
                        m_meta_valid <= '0;
                    end
                    if (last_hs) begin
                        data_done <= 1'b1;
                    end
                    if (pkt_done) begin
                        fwd_count    <= sat_inc(fwd_count);
                        meta_done    <= 1'b0;
                        data_done    <= 1'b0;
                        m_meta_valid <= '0;
                        meta_ready_r <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (last_hs) begin
                        drop_count   <= sat_inc(drop_count);
                        meta_ready_r <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_port_dispatch.sv
// Directed bench for udp_rx_port_dispatch: a drop-configured and a
// default-channel-configured instance share stimulus, selected by "which".
module tb_udp_rx_port_dispatch;

    localparam int W  = 64;
    localparam int NP = 4;
    localparam logic [63:0] STD = {16'd5003, 16'd5002, 16'd5001, 16'd5000};
    localparam logic [63:0] DUP = {16'd7000, 16'd5002, 16'd7000, 16'd5000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             which = 1'b0;
    logic             mv = 1'b0;
    logic [175:0]     md = '0;
    logic             dv = 1'b0;
    logic [W-1:0]     dd = '0;
    logic [W/8-1:0]   dk = '0;
    logic             dl = 1'b0;
    logic [NP-1:0]    mmr = '1;
    logic [NP-1:0]    mdr = '1;
    logic [16*NP-1:0] tbl = STD;
    logic [NP-1:0]    en = '1;

    logic             rnd_en = 1'b0;
    logic [NP-1:0]    rnd_mmr = '1;
    logic [NP-1:0]    rnd_mdr = '1;
    logic [NP-1:0]    mmr_eff, mdr_eff;
    assign mmr_eff = rnd_en ? rnd_mmr : mmr;
    assign mdr_eff = rnd_en ? rnd_mdr : mdr;

    logic          smr0, sdr0, smr1, sdr1, mdl0, mdl1;
    logic [NP-1:0] mmv0, mmv1, mdv0, mdv1;
    logic [175:0]  mmd0, mmd1;
    logic [W-1:0]  mdd0, mdd1;
    logic [W/8-1:0] mdk0, mdk1;
    logic [31:0]   fwd0, fwd1, drop0, drop1;

    udp_rx_port_dispatch #(.WIDTH(W), .NUM_PORTS(NP), .DEFAULT_EN(0), .DEFAULT_CH(0)) dut0 (
        .net_clk(clk), .net_aresetn(rst_n),
        .s_meta_valid(mv & ~which), .s_meta_ready(smr0), .s_meta_data(md),
        .s_data_valid(dv & ~which), .s_data_ready(sdr0), .s_data_data(dd),
        .s_data_keep(dk), .s_data_last(dl),
        .m_meta_valid(mmv0), .m_meta_ready(mmr_eff), .m_meta_data(mmd0),
        .m_data_valid(mdv0), .m_data_ready(mdr_eff), .m_data_data(mdd0),
        .m_data_keep(mdk0), .m_data_last(mdl0),
        .port_table(tbl), .port_enable(en),
        .fwd_count(fwd0), .drop_count(drop0)
    );

    udp_rx_port_dispatch #(.WIDTH(W), .NUM_PORTS(NP), .DEFAULT_EN(1), .DEFAULT_CH(3)) dut1 (
        .net_clk(clk), .net_aresetn(rst_n),
        .s_meta_valid(mv & which), .s_meta_ready(smr1), .s_meta_data(md),
        .s_data_valid(dv & which), .s_data_ready(sdr1), .s_data_data(dd),
        .s_data_keep(dk), .s_data_last(dl),
        .m_meta_valid(mmv1), .m_meta_ready(mmr_eff), .m_meta_data(mmd1),
        .m_data_valid(mdv1), .m_data_ready(mdr_eff), .m_data_data(mdd1),
        .m_data_keep(mdk1), .m_data_last(mdl1),
        .port_table(tbl), .port_enable(en),
        .fwd_count(fwd1), .drop_count(drop1)
    );

    logic          smr, sdr, mdl;
    logic [NP-1:0] mmv, mdv;
    logic [175:0]  mmd;
    logic [W-1:0]  mdd;
    logic [W/8-1:0] mdk;
    assign smr = which ? smr1 : smr0;
    assign sdr = which ? sdr1 : sdr0;
    assign mmv = which ? mmv1 : mmv0;
    assign mdv = which ? mdv1 : mdv0;
    assign mmd = which ? mmd1 : mmd0;
    assign mdd = which ? mdd1 : mdd0;
    assign mdk = which ? mdk1 : mdk0;
    assign mdl = which ? mdl1 : mdl0;

    int checks = 0, errors = 0;
    int exp_fwd0 = 0, exp_drop0 = 0, exp_fwd1 = 0;
    int beat_seq = 0;
    int cyc = 0, t0 = 0, meta_lat = -1, stalls = 0, pt_bad = 0;
    logic [NP-1:0] mm_acc, dm_acc;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        for (int j = 0; j < NP; j++) begin
            rnd_mmr[j] = ($urandom_range(0, 3) != 0);
            rnd_mdr[j] = ($urandom_range(0, 3) != 0);
        end
    end

    // Downstream monitor: every accepted output beat must carry the next value
    // of the driver's sequence.
    logic mon_en = 1'b0;
    int   mon_base = 0, mon_beats = 0, mon_err = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            if ((mdv & mdr_eff) != 0) begin
                if (mdd !== W'(mon_base + mon_beats)) mon_err++;
                mon_beats++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic sample();
        #1;
        if (meta_lat < 0 && mmv != 0) meta_lat = cyc - t0;
        if (mmv != 0 && mmd !== md) pt_bad++;
        if (mdv != 0 && (mdd !== dd || mdk !== dk || mdl !== dl)) pt_bad++;
        mm_acc |= mmv;
        dm_acc |= mdv;
    endtask

    task automatic put_meta(input logic [15:0] port, input int nbeats);
        int t = 0;
        mv = 1'b1;
        md = {16'(nbeats * 8), port, 16'd4000, 128'hC0A8_0001_0000_0000_0000_0000_0A00_0002};
        while (!smr && t < 50) begin @(negedge clk); t++; end
        chk("meta_accept", {63'd0, smr}, 64'd1);
        t0 = cyc;
        mm_acc = '0; dm_acc = '0; meta_lat = -1; stalls = 0;
        @(negedge clk);
        mv = 1'b0;
    endtask

    task automatic put_beats(input int n);
        int t;
        for (int b = 0; b < n; b++) begin
            dv = 1'b1; dd = W'(beat_seq); dk = '1; dl = (b == n - 1);
            t = 0;
            sample();
            while (!sdr && t < 50) begin @(negedge clk); t++; stalls++; sample(); end
            chk("beat_accept", {63'd0, sdr}, 64'd1);
            beat_seq++;
            @(negedge clk);
        end
        dv = 1'b0; dl = 1'b0;
    endtask

    task automatic finish_pkt(output logic rdy_now);
        int t = 0;
        rdy_now = smr;
        while (!smr && t < 50) begin sample(); @(negedge clk); t++; end
    endtask

    task automatic send_pkt(input logic [15:0] port, input int n, output logic rdy_now);
        put_meta(port, n);
        put_beats(n);
        finish_pkt(rdy_now);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_fwd0"}, 64'(fwd0), 64'(exp_fwd0));
        chk({tag, "_drop0"}, 64'(drop0), 64'(exp_drop0));
        chk({tag, "_fwd1"}, 64'(fwd1), 64'(exp_fwd1));
        chk({tag, "_drop1"}, 64'(drop1), 64'd0);
    endtask

    typedef struct {
        logic        which;
        logic [63:0] tbl;
        logic [3:0]  en;
        logic [15:0] port;
        int          nbeats;
        logic [3:0]  exp_ch;
    } vec_t;

    vec_t vec[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic rdy;
        int total;

        vec[0] = '{1'b0, STD, 4'hF, 16'd5002, 3, 4'b0100};
        vec[1] = '{1'b0, STD, 4'hF, 16'd5000, 1, 4'b0001};
        vec[2] = '{1'b0, STD, 4'hF, 16'd5003, 2, 4'b1000};
        vec[3] = '{1'b0, STD, 4'hF, 16'd6000, 4, 4'b0000};
        vec[4] = '{1'b1, STD, 4'hF, 16'd6000, 4, 4'b1000};
        vec[5] = '{1'b0, DUP, 4'b1101, 16'd7000, 2, 4'b1000};
        vec[6] = '{1'b0, DUP, 4'hF, 16'd7000, 2, 4'b0010};
        vec[7] = '{1'b0, STD, 4'h0, 16'd5000, 1, 4'b0000};
        vec[8] = '{1'b1, STD, 4'hF, 16'd5001, 1, 4'b0010};

        repeat (2) @(negedge clk);
        chk("rst_mmv0", 64'(mmv0), 64'd0);
        chk("rst_mmv1", 64'(mmv1), 64'd0);
        chk("rst_smr", {62'd0, smr0, smr1}, 64'd0);
        chk("rst_sdr", {62'd0, sdr0, sdr1}, 64'd0);
        chk("rst_mmd", 64'(mmd0[175:128]), 64'd0);
        check_counts("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            which = vec[i].which; tbl = vec[i].tbl; en = vec[i].en;
            @(negedge clk);
            send_pkt(vec[i].port, vec[i].nbeats, rdy);
            chk($sformatf("v%0d_meta_ch", i), 64'(mm_acc), 64'(vec[i].exp_ch));
            chk($sformatf("v%0d_data_ch", i), 64'(dm_acc), 64'(vec[i].exp_ch));
            chk($sformatf("v%0d_first_stall", i), 64'(stalls), 64'd1);
            chk($sformatf("v%0d_ready_after", i), {63'd0, rdy}, 64'd1);
            if (vec[i].exp_ch != 0) chk($sformatf("v%0d_meta_lat", i), 64'(meta_lat), 64'd2);
            if (vec[i].which) exp_fwd1++;
            else if (vec[i].exp_ch != 0) exp_fwd0++;
            else exp_drop0++;
            check_counts($sformatf("v%0d", i));
        end

        // Metadata backpressure while the payload completes.
        which = 1'b0; tbl = STD; en = '1; mmr = 4'b1110;
        @(negedge clk);
        begin
            int held_bad = 0, rdy_bad = 0;
            put_meta(16'd5000, 2);
            put_beats(2);
            for (int k = 0; k < 10; k++) begin
                #1;
                if (mmv !== 4'b0001) held_bad++;
                if (smr) rdy_bad++;
                @(negedge clk);
            end
            chk("bp_meta_held", 64'(held_bad), 64'd0);
            chk("bp_no_meta_ready", 64'(rdy_bad), 64'd0);
            chk("bp_data_ch", 64'(dm_acc), 64'b0001);
            mmr = '1;
            @(negedge clk);
            chk("bp_done_ready", {63'd0, smr}, 64'd1);
            chk("bp_meta_cleared", 64'(mmv), 64'd0);
            exp_fwd0++;
            check_counts("bp");
        end

        // Table rewrite after lookup must not redirect the in-flight packet.
        @(negedge clk);
        put_meta(16'd5000, 2);
        @(negedge clk);
        tbl[15:0] = 16'd9000;
        put_beats(2);
        finish_pkt(rdy);
        chk("tblchg_meta_ch", 64'(mm_acc), 64'b0001);
        chk("tblchg_data_ch", 64'(dm_acc), 64'b0001);
        exp_fwd0++;
        send_pkt(16'd5000, 1, rdy);
        chk("tblchg_next_dropped", 64'(mm_acc | dm_acc), 64'd0);
        exp_drop0++;
        check_counts("tblchg");

        // Asynchronous reset in the middle of a forwarded packet.
        tbl = STD;
        @(negedge clk);
        put_meta(16'd5001, 3);
        @(negedge clk);
        chk("rstmid_pre_mmv", 64'(mmv), 64'b0010);
        dv = 1'b1; dd = W'(beat_seq); dl = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_mmv", 64'(mmv), 64'd0);
        chk("rstmid_mdv", 64'(mdv), 64'd0);
        chk("rstmid_smr", {63'd0, smr}, 64'd0);
        exp_fwd0 = 0; exp_drop0 = 0; exp_fwd1 = 0;
        check_counts("rstmid");
        dv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(16'd5001, 2, rdy);
        chk("rstmid_after_ch", 64'(mm_acc & dm_acc), 64'b0010);
        exp_fwd0++;
        check_counts("rstmid_after");

        // 100 back-to-back packets with random downstream stalls.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_fwd0 = 0; exp_drop0 = 0; exp_fwd1 = 0;
        total = 0;
        mon_base = beat_seq;
        rnd_en = 1'b1; mon_en = 1'b1;
        begin
            int ch_bad = 0;
            for (int k = 0; k < 100; k++) begin
                send_pkt(16'(5000 + k % 4), 1 + k % 4, rdy);
                total += 1 + k % 4;
                if (mm_acc !== 4'(1 << (k % 4)) || dm_acc !== 4'(1 << (k % 4))) ch_bad++;
            end
            repeat (3) @(negedge clk);
            rnd_en = 1'b0; mon_en = 1'b0;
            chk("b2b_channel_errors", 64'(ch_bad), 64'd0);
        end
        chk("b2b_fwd_count", 64'(fwd0), 64'd100);
        chk("b2b_beats", 64'(mon_beats), 64'(total));
        chk("b2b_order_errors", 64'(mon_err), 64'd0);
        chk("passthrough_errors", 64'(pt_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
